// File: rtl/spu_fetch_queue.sv
// Instruction-fetch front end: issues 8-byte-aligned local-store reads, buffers the
// returned instruction pairs in a small FIFO and hands them to IF/ID with valid/ready.
module spu_fetch_queue #(
  parameter int PC_W  = 11,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_enable,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_rd_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [63:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst1,
  output logic [31:0]     id_inst2,
  output logic [PC_W-1:0] id_pc_plus8
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     inst1;
    logic [31:0]     inst2;
    logic [PC_W-1:0] pc_plus8;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_inflight;
  logic [PC_W-1:0]   r_inflight_addr;

  logic [CNT_W-1:0]  w_credit;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic [PC_W-1:0]   w_redirect_aligned;
  entry_t            w_head;

  // An inflight fetch already holds a slot, so the queue can never overflow.
  assign w_credit           = r_count + CNT_W'(r_inflight);
  assign w_req              = reset && pc_enable && !redirect && (w_credit < CNT_W'(DEPTH));
  assign w_push             = reset && r_inflight && !redirect;
  assign w_pop              = id_valid && id_ready && !redirect;
  assign w_redirect_aligned = redirect_pc & ~PC_W'(7);

  assign imem_rd_en  = w_req;
  assign imem_addr   = r_pc;
  assign id_valid    = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign id_inst1    = id_valid ? w_head.inst1    : '0;
  assign id_inst2    = id_valid ? w_head.inst2    : '0;
  assign id_pc_plus8 = id_valid ? w_head.pc_plus8 : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc            <= '0;
      r_count         <= '0;
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else if (redirect) begin
      // Redirect overrides everything: flush, drop the pending response, reload PC.
      r_pc       <= w_redirect_aligned;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_inflight <= w_req;
      if (w_req) begin
        r_pc            <= r_pc + PC_W'(8);
        r_inflight_addr <= r_pc;
      end
    end
  end

  // NOTE: queue storage has no reset; outputs are masked to zero while count is zero,
  // so stale slot contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{inst1:    imem_rdata[63:32],
                           inst2:    imem_rdata[31:0],
                           pc_plus8: r_inflight_addr + PC_W'(8)};
    end
  end

endmodule

// File: tb/tb_spu_fetch_queue.sv
// Self-checking bench for spu_fetch_queue: queue-based reference model compared every
// cycle, directed literal checks for the key timing points, then randomized traffic.
module tb_spu_fetch_queue;

  localparam int PC_W  = 11;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            pc_enable;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [63:0]     imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst1;
  logic [31:0]     id_inst2;
  logic [PC_W-1:0] id_pc_plus8;

  always #5 clk = ~clk;

  spu_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_enable   (pc_enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst1    (id_inst1),
    .id_inst2    (id_inst2),
    .id_pc_plus8 (id_pc_plus8)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Local store contents: one random 64-bit pair per aligned address.
  logic [63:0] tbl [256];

  // Local store: answers one cycle after a request, garbage otherwise.
  always @(posedge clk)
    imem_rdata <= imem_rd_en ? tbl[imem_addr[10:3]] : {$urandom, $urandom};

  // Reference model: a plain queue of pairs plus at most one pending fetch.
  typedef struct {
    logic [31:0]     i1;
    logic [31:0]     i2;
    logic [PC_W-1:0] p8;
  } ent_t;

  ent_t            mq [$];
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_pend_addr;
  bit              m_pend;
  bit              m_live = 1'b0;
  bit              m_req;
  bit              m_pop;
  ent_t            m_e;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_pc   = '0;
      m_pend = 1'b0;
      m_live = 1'b1;
    end else if (redirect) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = redirect_pc & 11'h7F8;
    end else begin
      m_req = pc_enable && (mq.size() + int'(m_pend) < DEPTH);
      m_pop = (mq.size() > 0) && id_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_pend) begin
        m_e.i1 = tbl[m_pend_addr[10:3]][63:32];
        m_e.i2 = tbl[m_pend_addr[10:3]][31:0];
        m_e.p8 = m_pend_addr + 11'd8;
        mq.push_back(m_e);
      end
      m_pend = m_req;
      if (m_req) begin
        m_pend_addr = m_pc;
        m_pc        = m_pc + 11'd8;
      end
    end
  end

  bit exp_rd;

  always @(negedge clk) begin
    if (m_live) begin
      exp_rd = reset && pc_enable && !redirect && (mq.size() + int'(m_pend) < DEPTH);
      check("model_rd_en", imem_rd_en, exp_rd);
      check("model_addr",  imem_addr,  m_pc);
      check("model_valid", id_valid,   mq.size() != 0);
      if (mq.size() > 0) begin
        check("model_inst1", id_inst1,    mq[0].i1);
        check("model_inst2", id_inst2,    mq[0].i2);
        check("model_pc8",   id_pc_plus8, mq[0].p8);
      end else begin
        check("model_zero", {id_inst1, id_inst2}, 64'd0);
        check("model_pc8z", id_pc_plus8, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = {$urandom, $urandom};
    reset = 1'b0; pc_enable = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset state
    cyc(); cyc();
    neg();
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_addr",  imem_addr,  0);
    check("rst_valid", id_valid,   0);
    check("rst_pc8",   id_pc_plus8, 0);
    check("rst_inst",  {id_inst1, id_inst2}, 0);

    // Streaming from address 0
    cyc(); reset = 1'b1; pc_enable = 1'b1; id_ready = 1'b1;
    neg();
    check("c0_rd_en", imem_rd_en, 1);
    check("c0_addr",  imem_addr,  0);
    check("c0_valid", id_valid,   0);
    cyc(); neg();
    check("c1_addr",  imem_addr, 8);
    check("c1_valid", id_valid,  0);
    cyc(); neg();
    check("c2_valid", id_valid,    1);
    check("c2_pc8",   id_pc_plus8, 8);
    check("c2_inst1", id_inst1,    tbl[0][63:32]);
    check("c2_addr",  imem_addr,   16);
    for (int k = 3; k < 8; k++) begin
      cyc(); neg();
      check("stream_valid", id_valid,    1);
      check("stream_pc8",   id_pc_plus8, 8 * (k - 1));
      check("stream_addr",  imem_addr,   8 * k);
    end

    // Decode stall for 10 cycles, then drain in order without gaps
    cyc(); id_ready = 1'b0;
    repeat (9) cyc();
    neg();
    check("stall_rd_en", imem_rd_en, 0);
    check("stall_valid", id_valid,   1);
    cyc(); id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      neg();
      check("drain_valid", id_valid,    1);
      check("drain_pc8",   id_pc_plus8, 56 + 8 * k);
      cyc();
    end

    // Redirect with entries buffered and a fetch inflight
    id_ready = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 11'h105; id_ready = 1'b1;
    neg();
    check("redir_rd_en", imem_rd_en, 0);
    cyc(); redirect = 1'b0;
    neg();
    check("redir1_valid", id_valid,   0);
    check("redir1_addr",  imem_addr,  11'h100);
    check("redir1_rd_en", imem_rd_en, 1);
    cyc(); neg();
    check("redir2_valid", id_valid,  0);
    check("redir2_addr",  imem_addr, 11'h108);
    cyc(); neg();
    check("redir3_valid", id_valid,    1);
    check("redir3_pc8",   id_pc_plus8, 11'h108);

    // PC wrap at the top of the local store
    cyc(); redirect = 1'b1; redirect_pc = 11'h7F8;
    cyc(); redirect = 1'b0;
    neg(); check("wrap_addr0", imem_addr, 11'h7F8);
    cyc(); neg(); check("wrap_addr1", imem_addr, 11'h000);
    cyc(); neg();
    check("wrap_valid", id_valid,    1);
    check("wrap_pc8a",  id_pc_plus8, 11'h000);
    cyc(); neg(); check("wrap_pc8b", id_pc_plus8, 11'h008);

    // pc_enable dropped while a request is inflight
    cyc(); redirect = 1'b1; redirect_pc = 11'h200;
    cyc(); redirect = 1'b0;
    neg(); check("hold_req", imem_addr, 11'h200);
    cyc(); pc_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      neg();
      check("hold_rd_en", imem_rd_en, 0);
      check("hold_addr",  imem_addr,  11'h208);
      if (i == 1) begin
        check("hold_valid", id_valid,    1);
        check("hold_pc8",   id_pc_plus8, 11'h208);
      end
      if (i == 3) check("hold_empty", id_valid, 0);
      cyc();
    end
    pc_enable = 1'b1;
    neg();
    check("resume_rd_en", imem_rd_en, 1);
    check("resume_addr",  imem_addr,  11'h208);

    // Reset with a full queue
    cyc(); id_ready = 1'b0;
    repeat (7) cyc();
    neg();
    check("full_valid", id_valid,   1);
    check("full_rd_en", imem_rd_en, 0);
    cyc(); reset = 1'b0; id_ready = 1'b1;
    cyc(); reset = 1'b1;
    neg();
    check("rst2_valid", id_valid,   0);
    check("rst2_addr",  imem_addr,  0);
    check("rst2_rd_en", imem_rd_en, 1);
    cyc(); neg();
    check("rst2_addr1", imem_addr, 8);
    check("rst2_empty", id_valid,  0);
    cyc(); neg();
    check("rst2_pc8",   id_pc_plus8, 8);

    // Randomized traffic against the model
    repeat (2000) begin
      cyc();
      reset       = ($urandom_range(99) != 0);
      pc_enable   = ($urandom_range(9) < 8);
      id_ready    = ($urandom_range(9) < 6);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = PC_W'($urandom);
    end
    cyc();
    neg();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
